// File: rtl/stage_seq_if.sv
//==== stage_seq_if | control/strobe bundle between the stage sequencer and the datapath
//==== rev 1.0
`default_nettype none

interface stage_seq_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             step;
  logic             halt_req;
  logic             mem_access;
  logic             mem_ready;
  logic             fe_en;
  logic             dc_en;
  logic             ex_en;
  logic             wb_en;
  logic             mem_req;
  logic [2:0]       phase;
  logic             busy;
  logic             halted;
  logic             bus_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, step, halt_req, mem_access, mem_ready,
    output fe_en, dc_en, ex_en, wb_en, mem_req, phase, busy, halted, bus_err, instr_count
  );

  modport slave (
    output run, step, halt_req, mem_access, mem_ready,
    input  fe_en, dc_en, ex_en, wb_en, mem_req, phase, busy, halted, bus_err, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/stage_seq.sv
//==== stage_seq | FE/DC/EX/(MEM)/WB strobe sequencer with run/step/halt and RAM timeout
//==== rev 1.0
`default_nettype none

module stage_seq #(
  parameter int RAM_TIMEOUT = 15,
  parameter int CNT_W       = 32,
  parameter int TO_W        = 8
) (
  input  wire               clk,
  input  wire               rst_n,
  stage_seq_if.master       bus
);

  // State codes double as the phase output encoding.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FE   = 3'd1,
    S_DC   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RAM_TIMEOUT - 1);

  state_t           state;
  state_t           state_nxt;
  logic             step_mode;
  logic             halt_flag;
  logic             mem_flag;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      step_mode <= 1'b0;
      halt_flag <= 1'b0;
      mem_flag  <= 1'b0;
      to_cnt    <= '0;
      count     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (bus.step)
            step_mode <= 1'b1;
          else if (bus.run)
            step_mode <= 1'b0;
        end
        S_DC: begin
          halt_flag <= bus.halt_req;
          mem_flag  <= bus.mem_access;
        end
        S_EX:  to_cnt <= '0;
        S_MEM: if (!bus.mem_ready) to_cnt <= to_cnt + 1'b1;
        S_WB:  count <= count + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.step || bus.run) state_nxt = S_FE;
      S_FE:   state_nxt = S_DC;
      S_DC:   state_nxt = S_EX;
      S_EX:   state_nxt = mem_flag ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.mem_ready)
          state_nxt = S_WB;
        else if ((RAM_TIMEOUT != 0) && (to_cnt == TO_LAST))
          state_nxt = S_ERR;
      end
      S_WB: begin
        if (halt_flag)
          state_nxt = S_HALT;
        else if (step_mode || !bus.run)
          state_nxt = S_IDLE;
        else
          state_nxt = S_FE;
      end
      S_HALT:  state_nxt = S_HALT;
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.fe_en       = (state == S_FE);
  assign bus.dc_en       = (state == S_DC);
  assign bus.ex_en       = (state == S_EX);
  assign bus.wb_en       = (state == S_WB);
  assign bus.mem_req     = (state == S_MEM);
  assign bus.phase       = state;
  assign bus.busy        = (state == S_FE) || (state == S_DC) || (state == S_EX) ||
                           (state == S_MEM) || (state == S_WB);
  assign bus.halted      = (state == S_HALT);
  assign bus.bus_err     = (state == S_ERR);
  assign bus.instr_count = count;

endmodule

`default_nettype wire

// File: doc/stage_seq.md
Name: stage_seq

Overview:
Single-clock sequencer for the four-stage FE/DC/EX/WB instruction datapath. It produces one-cycle stage-enable strobes in strict rotation and inserts a RAM wait stage for memory instructions. It also supports run/single-step/halt control, flags RAM timeouts and counts retired instructions. The stage registers use these strobes as clock enables on the common clock.

Parameters:
RAM_TIMEOUT, 15, max consecutive MEM cycles with mem_ready low before bus error; 0 disables the timeout
CNT_W, 32, width of retired-instruction counter
TO_W, 8, width of timeout counter; must satisfy 2^TO_W > RAM_TIMEOUT

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
run  input  1  level; continuous execution while high
step  input  1  pulse; execute exactly one instruction from IDLE
halt_req  input  1  from decode; current instruction is HALT, sampled only in DC state
mem_access  input  1  from decode; current instruction accesses RAM, sampled only in DC state
mem_ready  input  1  RAM acknowledge, sampled only in MEM state
fe_en  output  1  fetch-stage enable strobe
dc_en  output  1  decode-stage enable strobe
ex_en  output  1  execute-stage enable strobe
wb_en  output  1  writeback-stage enable strobe
mem_req  output  1  RAM request, high throughout MEM state
phase  output  3  0 idle, 1 FE, 2 DC, 3 EX, 4 MEM, 5 WB, 6 HALT, 7 ERR
busy  output  1  high in FE/DC/EX/MEM/WB
halted  output  1  sticky; HALT state reached
bus_err  output  1  sticky; RAM timeout occurred
instr_count  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock (clk); synchronous, active-low reset (rst_n). Reset is sampled on the rising edge of clk only.
- Reset values: state IDLE; all enables 0; mem_req 0; phase 0; busy 0; halted 0; bus_err 0; instr_count 0; step_mode 0; latched halt/mem flags 0; timeout counter 0.
- Reset mid-operation, including MEM, returns to IDLE on the next edge. mem_req drops, and no wb_en is issued for the aborted instruction.
- All outputs decode from registered state and counters only; there is no combinational input-to-output path.
- At most one enable is high per cycle; each enable is high for exactly one cycle per instruction.
- IDLE:
  - step=1 -> FE with step_mode=1. step wins if run is also 1.
  - Else run=1 -> FE with step_mode=0.
  - Else stay in IDLE.
- FE: fe_en=1 -> DC.
- DC: dc_en=1; latch halt_req and mem_access -> EX.
- EX: ex_en=1. Go to MEM if the mem flag is latched, else WB. Clear the timeout counter.
- MEM: mem_req=1.
  - mem_ready=1 -> WB.
  - Else, with RAM_TIMEOUT≠0 and counter==RAM_TIMEOUT-1 -> ERR.
  - Else counter+1 and stay in MEM.
- WB: wb_en=1; instr_count+1 (wraps). Then, in priority order:
  - halt flag latched -> HALT.
  - step_mode=1 or run=0 -> IDLE.
  - Else -> FE.
- HALT: halted=1; stay in HALT until reset; ignore run/step.
- ERR: bus_err=1; no wb_en for the failed instruction; stay in ERR until reset; not counted.
- Latency, fe_en at cycle t:
  - Non-memory instruction: wb_en at t+3, next fe_en at t+4.
  - Memory instruction with mem_ready first high k cycles after entering MEM (k≥0): wb_en at t+4+k, next fe_en at t+5+k.
- run falling mid-instruction: the instruction completes through WB, then IDLE. There are no partial instructions.
- step pulses received while busy are ignored (not queued).
- halt_req and mem_access both set: MEM is performed first, then WB, then HALT.

Test Plan:
- Reset, then run=1, all inputs 0 -> fe/dc/ex/wb strobes at cycles 1,2,3,4 repeat every 4 cycles; instr_count=3 after 12 cycles; mem_req never high.
- mem_access=1 in DC, mem_ready rises after 2 MEM cycles -> mem_req high 3 cycles; wb_en at t+6; instr_count +1.
- step pulse with run=0 -> exactly one FE..WB sequence, back to IDLE; a second step pulse during busy is ignored and count=1.
- halt_req=1 in DC, run=1 -> wb_en once, then halted=1 and phase=6; no further fe_en for 20 cycles; count +1.
- mem_access=1, mem_ready held 0, RAM_TIMEOUT=15 -> mem_req high exactly 15 cycles; then bus_err=1, phase=7, no wb_en, count unchanged.
- rst_n=0 for one edge during MEM -> next cycle phase=0, mem_req=0, count=0; run=1 restarts with fe_en next cycle.
